dma_copy: RTL and testbench

DMA_COPY -- requirements
Module: dma_copy

---
 rtl/dma_copy_if.sv | 29 ++
 rtl/dma_copy.sv | 122 ++++++++++++
 tb/tb_dma_copy.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_copy_if.sv
// Bus bundle for dma_copy: the copy request and its status on one side, the
// single word-wide memory port on the other.
interface dma_copy_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic             mem_we;
    logic [31:0]      mem_a;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;

    // Requester / memory side (drives requests and read data)
    modport master (
        output start, src, dst, len, mem_rd,
        input  busy, done, err, mem_we, mem_a, mem_wd
    );

    // Copy engine side
    modport slave (
        input  start, src, dst, len, mem_rd,
        output busy, done, err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/dma_copy.sv
// Word-by-word memory copy engine: one read cycle then one write cycle per
// word, ascending addresses, single shared memory port.
//
//  state | meaning
//  IDLE  | waiting for start; memory port quiet
//  RD    | mem_a = source pointer, read data captured at the edge
//  WR    | mem_a = destination pointer, captured word written
//  DONE  | one-cycle done pulse, then back to IDLE
module dma_copy #(
    parameter int LEN_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    dma_copy_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] remain;
    logic [31:0]      data;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wd_q;

    logic misaligned;
    assign misaligned = (bus.src[1:0] != 2'b00) || (bus.dst[1:0] != 2'b00);

    // Sequencer with all outputs registered; reset clears them asynchronously
    // so an in-flight write is dropped without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            remain  <= '0;
            data    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (misaligned) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else if (bus.len == '0) begin
                            err_q  <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            src_ptr <= bus.src;
                            dst_ptr <= bus.dst;
                            remain  <= bus.len;
                            busy_q  <= 1'b1;
                            addr_q  <= bus.src;
                            state   <= RD;
                        end
                    end
                end
                RD: begin
                    data   <= bus.mem_rd;
                    wd_q   <= bus.mem_rd;
                    addr_q <= dst_ptr;
                    we_q   <= 1'b1;
                    state  <= WR;
                end
                WR: begin
                    src_ptr <= src_ptr + 32'd4;
                    dst_ptr <= dst_ptr + 32'd4;
                    remain  <= remain - 1'b1;
                    we_q    <= 1'b0;
                    wd_q    <= '0;
                    if (remain > LEN_W'(1)) begin
                        addr_q <= src_ptr + 32'd4;
                        state  <= RD;
                    end else begin
                        addr_q <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    we_q   <= 1'b0;
                    addr_q <= '0;
                    wd_q   <= '0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.mem_we = we_q;
    assign bus.mem_a  = addr_q;
    assign bus.mem_wd = wd_q;

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: a small word memory behind the port, and a reference
// model that performs each copy as a plain ascending loop over an array.
module tb_dma_copy;

    localparam int LW = 8;

    logic clk;
    logic reset;
    dma_copy_if #(.LEN_W(LW)) ifc ();

    dma_copy #(.LEN_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory: 256 words indexed by address bits [9:2]
    logic [31:0] mem [256];
    logic [31:0] model_mem [256];
    logic        bd_we;
    logic [7:0]  bd_idx;
    logic [31:0] bd_data;

    assign ifc.mem_rd = mem[ifc.mem_a[9:2]];

    always @(posedge clk) begin
        if (ifc.mem_we) mem[ifc.mem_a[9:2]] <= ifc.mem_wd;
        else if (bd_we) mem[bd_idx] <= bd_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic mem_put(input int idx, input logic [31:0] v);
        @(negedge clk);
        bd_idx  = 8'(idx);
        bd_data = v;
        bd_we   = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
        model_mem[idx] = v;
    endtask

    // Runs one request and checks timing, writes, err and final memory.
    task automatic run_xfer(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int poke);
        bit          mis;
        int          exp_busy, exp_done;
        logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
        logic [31:0] as, ad, v;
        int          busy_cnt, done_at, ndone, idle_bad, wr_bad, mem_bad;

        mis      = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        exp_busy = (mis || n == 0) ? 0 : 2 * n;
        exp_done = exp_busy + 1;
        if (!mis) begin
            for (int i = 0; i < n; i++) begin
                as = s + 32'(4 * i);
                ad = d + 32'(4 * i);
                v  = model_mem[as[9:2]];
                model_mem[ad[9:2]] = v;
                exp_a.push_back(ad);
                exp_d.push_back(v);
            end
        end

        @(negedge clk);
        ifc.start = 1'b1;
        ifc.src   = s;
        ifc.dst   = d;
        ifc.len   = LW'(n);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.src   = $urandom;
        ifc.dst   = $urandom;
        ifc.len   = LW'($urandom);

        busy_cnt = 0; done_at = 0; ndone = 0; idle_bad = 0;
        for (int c = 1; c <= exp_done + 2; c++) begin
            if (ifc.busy) busy_cnt++;
            if (ifc.done) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
            if (ifc.mem_we) begin
                got_a.push_back(ifc.mem_a);
                got_d.push_back(ifc.mem_wd);
            end
            if (!ifc.busy && (ifc.mem_we || ifc.mem_a != 0 || ifc.mem_wd != 0)) idle_bad++;
            if (ifc.busy && ifc.done) idle_bad++;
            if (c == poke) begin
                ifc.start = 1'b1;
                ifc.src   = s + 32'h40;
                ifc.dst   = d + 32'h80;
                ifc.len   = LW'(n + 2);
            end else if (c == poke + 1) begin
                ifc.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        ifc.start = 1'b0;

        n_cmp++;
        if (busy_cnt !== exp_busy) begin
            n_bad++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cnt, exp_busy);
        end
        n_cmp++;
        if (done_at !== exp_done || ndone !== 1) begin
            n_bad++;
            $display("FAIL %s done_cycle got %0d (pulses %0d) want %0d (pulses 1)", name, done_at, ndone, exp_done);
        end
        n_cmp++;
        if (ifc.err !== mis) begin
            n_bad++;
            $display("FAIL %s err got %b want %b", name, ifc.err, mis);
        end
        n_cmp++;
        if (idle_bad != 0) begin
            n_bad++;
            $display("FAIL %s idle_outputs got %0d bad cycles want 0", name, idle_bad);
        end
        wr_bad = 0;
        if (got_a.size() != exp_a.size()) wr_bad = 1;
        else
            for (int i = 0; i < exp_a.size(); i++)
                if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) wr_bad++;
        n_cmp++;
        if (wr_bad != 0) begin
            n_bad++;
            $display("FAIL %s writes got %0d writes want %0d (%0d bad)", name, got_a.size(), exp_a.size(), wr_bad);
        end
        mem_bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) mem_bad++;
        n_cmp++;
        if (mem_bad != 0) begin
            n_bad++;
            $display("FAIL %s memory got %0d differing words want 0", name, mem_bad);
        end
    endtask

    task automatic test_reset();
        ifc.start = 1'b0; ifc.src = '0; ifc.dst = '0; ifc.len = '0;
        bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ifc.busy, ifc.done, ifc.err, ifc.mem_we} !== 4'b0 || ifc.mem_a !== 0 || ifc.mem_wd !== 0) begin
            n_bad++;
            $display("FAIL reset_outputs got b%b d%b e%b we%b a%h wd%h want all 0",
                     ifc.busy, ifc.done, ifc.err, ifc.mem_we, ifc.mem_a, ifc.mem_wd);
        end
        for (int i = 0; i < 256; i++) mem_put(i, $urandom);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_basic();
        mem_put(0, 32'h11); mem_put(1, 32'h22); mem_put(2, 32'h33); mem_put(3, 32'h44);
        run_xfer("basic", 32'h00, 32'h40, 4, 0);
        n_cmp++;
        if (mem[16] !== 32'h11 || mem[17] !== 32'h22 || mem[18] !== 32'h33 || mem[19] !== 32'h44) begin
            n_bad++;
            $display("FAIL basic_dst got %h %h %h %h want 11 22 33 44", mem[16], mem[17], mem[18], mem[19]);
        end
    endtask

    task automatic test_zero_len();
        run_xfer("zero_len", 32'h10, 32'h20, 0, 0);
    endtask

    task automatic test_misaligned();
        run_xfer("misaligned", 32'h02, 32'h20, 3, 0);
        run_xfer("misaligned_dst", 32'h00, 32'h23, 1, 0);
        run_xfer("after_misaligned", 32'h60, 32'h70, 2, 0);
    endtask

    task automatic test_overlap();
        mem_put(0, 32'hAAAA_0001); mem_put(1, 32'hBBBB_0002); mem_put(2, 32'hCCCC_0003);
        run_xfer("overlap", 32'h00, 32'h04, 3, 0);
        n_cmp++;
        if (mem[1] !== 32'hAAAA_0001 || mem[2] !== 32'hAAAA_0001 || mem[3] !== 32'hAAAA_0001) begin
            n_bad++;
            $display("FAIL overlap_words got %h %h %h want AAAA0001 x3", mem[1], mem[2], mem[3]);
        end
    endtask

    task automatic test_busy_start();
        run_xfer("busy_start", 32'h100, 32'h180, 5, 3);
        run_xfer("start_in_done", 32'h140, 32'h1C0, 2, 5);
    endtask

    task automatic test_wrap();
        run_xfer("wrap", 32'hFFFF_FFF8, 32'h0000_0100, 3, 0);
    endtask

    task automatic test_random();
        logic [31:0] s, d;
        int n;
        for (int k = 0; k < 8; k++) begin
            s = 32'($urandom_range(0, 120)) * 4;
            d = 32'($urandom_range(0, 120)) * 4;
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 5) == 0) s[1:0] = 2'($urandom_range(1, 3));
            run_xfer($sformatf("random%0d", k), s, d, n, 0);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 32; i < 36; i++) mem_put(i, $urandom);
        @(negedge clk);
        ifc.start = 1'b1; ifc.src = 32'h80; ifc.dst = 32'hC0; ifc.len = LW'(4);
        @(posedge clk);
        #1 ifc.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ifc.mem_we !== 1'b1 || ifc.mem_a !== 32'hC4) begin
            n_bad++;
            $display("FAIL rst_mid_wr got we%b a%h want we1 aC4", ifc.mem_we, ifc.mem_a);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({ifc.busy, ifc.done, ifc.err, ifc.mem_we} !== 4'b0 || ifc.mem_a !== 0 || ifc.mem_wd !== 0) begin
            n_bad++;
            $display("FAIL rst_mid_async got b%b d%b e%b we%b a%h wd%h want all 0",
                     ifc.busy, ifc.done, ifc.err, ifc.mem_we, ifc.mem_a, ifc.mem_wd);
        end
        model_mem[48] = model_mem[32];
        begin
            int dseen = 0;
            repeat (2) begin
                @(posedge clk);
                #1 if (ifc.done || ifc.mem_we) dseen++;
            end
            n_cmp++;
            if (dseen != 0) begin
                n_bad++;
                $display("FAIL rst_mid_quiet got %0d active cycles want 0", dseen);
            end
        end
        reset = 1'b0;
        run_xfer("after_reset", 32'h80, 32'hC0, 4, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_misaligned();
        test_overlap();
        test_busy_start();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
